// File: rtl/add_seq_pkg.sv
// Shared encodings for the multi-precision add/subtract sequencer.
package add_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/adder_8bit_cin.sv
// 8-bit ripple adder built from full_adder cells, with a usable carry-in so
// bytes can be chained across cycles.
module adder_8bit_cin (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout
);

   logic [8:0] c;

   assign c[0] = cin;
   assign cout = c[8];

   for (genvar i = 0; i < 8; i++) begin : g_bit
      full_adder u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (c[i]),
         .s    (sum[i]),
         .cout (c[i+1])
      );
   end

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/add_seq_ctrl.sv
// Multi-precision add/subtract sequencer: one shared 8-bit adder is stepped
// LSB byte first, with the inter-byte carry held in carry_q.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; operands latched on acceptance
// RUN     | one byte per cycle through the shared adder, idx_q = byte
// DONE    | one-cycle done pulse; sum/cout valid
module add_seq_ctrl
   import add_seq_pkg::*;
#(
   parameter int NBYTES = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  op,
   input  logic [8*NBYTES-1:0]   a,
   input  logic [8*NBYTES-1:0]   b,
   output logic                  busy,
   output logic                  done,
   output logic [8*NBYTES-1:0]   sum,
   output logic                  cout
);

   localparam int W    = 8 * NBYTES;
   localparam int IDXW = $clog2(NBYTES);

   state_t            state_q, state_d;
   logic [IDXW-1:0]   idx_q;
   logic              carry_q;
   logic              cout_q;
   logic [W-1:0]      a_q, b_q, sum_q;
   logic              load, step, last;
   logic [7:0]        add_sum;
   logic              add_cout;

   assign last = (idx_q == IDXW'(NBYTES - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_RUN;
         ST_RUN:  if (last)  state_d = ST_DONE;
         ST_DONE:            state_d = ST_IDLE;
         default:            state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      load = 1'b0;
      step = 1'b0;
      case (state_q)
         ST_IDLE: load = start;
         ST_RUN:  begin busy = 1'b1; step = 1'b1; end
         ST_DONE: begin busy = 1'b1; done = 1'b1; end
         default: ;
      endcase
   end

   adder_8bit_cin u_add (
      .a    (a_q[{idx_q, 3'b000} +: 8]),
      .b    (b_q[{idx_q, 3'b000} +: 8]),
      .cin  (carry_q),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // Subtract is A + ~B + 1: B is inverted on load and the +1 is the byte-0 carry-in.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
      end else if (load) begin
         a_q     <= a;
         b_q     <= (op == OP_SUB) ? ~b : b;
         carry_q <= (op == OP_SUB);
         idx_q   <= '0;
      end else if (step) begin
         sum_q[{idx_q, 3'b000} +: 8] <= add_sum;
         carry_q                     <= add_cout;
         if (last) cout_q <= add_cout;
         else      idx_q  <= idx_q + 1'b1;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed and randomized checks of add_seq_ctrl (NBYTES=4) against an
// arithmetic reference model.
module tb_add_seq_ctrl;

   localparam int NB = 4;
   localparam int W  = 8 * NB;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          op;
   logic [W-1:0]  a, b;
   logic          busy, done, cout;
   logic [W-1:0]  sum;

   int vectors     = 0;
   int miscompares = 0;

   add_seq_ctrl #(.NBYTES(NB)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain W+1-bit arithmetic; for subtract cout means "no borrow".
   function automatic logic [W:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic o);
      logic [W:0] r;
      if (!o) r = {1'b0, x} + {1'b0, y};
      else    r = {(x >= y), x - y};
      return r;
   endfunction

   task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic o);
      int n;
      logic [W:0] r;
      r = ref_op(x, y, o);
      @(negedge clk);
      a = x; b = y; op = o; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = $urandom; b = $urandom; op = 1'($urandom);
      n = 1;
      while (!done && n < 12) begin
         check({tag, "_busy_run"}, 64'(busy), 64'd1);
         @(negedge clk);
         n++;
      end
      check({tag, "_latency"}, 64'(n), 64'(NB + 1));
      check({tag, "_sum"},     64'(sum),  64'(r[W-1:0]));
      check({tag, "_cout"},    64'(cout), 64'(r[W]));
      check({tag, "_busy_done"}, 64'(busy), 64'd1);
      @(negedge clk);
      check({tag, "_done_pulse"}, 64'(done), 64'd0);
      check({tag, "_busy_idle"},  64'(busy), 64'd0);
   endtask

   initial begin
      logic [W:0] r;
      logic [W-1:0] x, y;
      logic o;

      reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_sum",  64'(sum),  64'd0);
      check("rst_cout", 64'(cout), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      run_op("t1_add",    32'h0000_00FF, 32'h0000_0001, 1'b0);
      run_op("t2_ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      run_op("t3_sub_borrow", 32'h0000_0000, 32'h0000_0001, 1'b1);
      run_op("t3_sub",    32'h1234_5678, 32'h0234_5678, 1'b1);

      // start re-pulsed during RUN (n=2) and DONE (n=5) must be ignored
      r = ref_op(32'h1111_1111, 32'h2222_2222, 1'b0);
      @(negedge clk);
      a = 32'h1111_1111; b = 32'h2222_2222; op = 1'b0; start = 1'b1;
      for (int n = 1; n <= 9; n++) begin
         @(negedge clk);
         start = (n == 2 || n == 5);
         a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; op = 1'b1;
         check("t4_done", 64'(done), 64'(n == NB + 1));
         check("t4_busy", 64'(busy), 64'(n <= NB + 1));
         if (n == NB + 1) begin
            check("t4_sum",  64'(sum),  64'(r[W-1:0]));
            check("t4_cout", 64'(cout), 64'(r[W]));
         end
      end
      start = 1'b0;

      // reset in the 2nd RUN cycle
      @(negedge clk);
      a = 32'hAAAA_AAAA; b = 32'h5555_5555; op = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("t5_sum",  64'(sum),  64'd0);
      check("t5_cout", 64'(cout), 64'd0);
      check("t5_busy", 64'(busy), 64'd0);
      check("t5_done", 64'(done), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         check("t5_no_done", 64'(done), 64'd0);
         check("t5_idle",    64'(busy), 64'd0);
      end
      run_op("t5_after", 32'h0101_0101, 32'h0101_0101, 1'b0);

      for (int i = 0; i < 1000; i++) begin
         case ($urandom_range(0, 7))
            0:       x = '1;
            1:       x = '0;
            default: x = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0:       y = '1;
            1:       y = 32'd1;
            2:       y = x;
            default: y = $urandom;
         endcase
         o = 1'($urandom);
         for (int g = $urandom_range(0, 2); g > 0; g--) begin
            @(negedge clk);
            check("rnd_gap_done", 64'(done), 64'd0);
         end
         run_op("rnd", x, y, o);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
